reset_mux_n: RTL and testbench



---
 rtl/reset_mux_pkg.sv | 15 +
 rtl/reset_sync_n.sv | 23 ++
 rtl/reset_mux_n.sv | 97 +++++++++
 tb/tb_reset_mux_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_mux_pkg.sv
// Shared types and helpers for the reset_mux_n switchover selector.
package reset_mux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Counter must hold the value HOLD_CYCLES itself.
   function automatic int hold_cnt_width(input int hold_cycles);
      return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
   endfunction

endpackage

// File: rtl/reset_sync_n.sv
// Two-flop reset synchroniser: asynchronous assert, deassert after two CLK edges.
module reset_sync_n (
   input  logic CLK,
   input  logic ARST_N,
   output logic RST_N_OUT
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= 1'b1;
         sync_p1 <= sync_p0;
      end
   end

   assign RST_N_OUT = sync_p1;

endmodule

// File: rtl/reset_mux_n.sv
// N-way active-low reset selector with forced-reset window around every switchover.
// Optional RESET_MUX_N_SYNC_EN adds a 2-flop deassert synchroniser on RST_OUT.
module reset_mux_n
   import reset_mux_pkg::*;
#(
   parameter int NUM_RST     = 4,
   parameter int SEL_WIDTH   = 2,
   parameter int HOLD_CYCLES = 2,
   parameter int INIT_SEL    = 0
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [SEL_WIDTH-1:0] SELECT,
   input  logic                 SELECT_ENABLE,
   input  logic [NUM_RST-1:0]   RST_IN,
   output logic                 RST_OUT,
   output logic [SEL_WIDTH-1:0] SEL_OUT,
   output logic                 BUSY
);

   localparam int                   CNT_W  = hold_cnt_width(HOLD_CYCLES);
   localparam logic [SEL_WIDTH-1:0] INIT_V = SEL_WIDTH'(INIT_SEL);
   localparam logic [CNT_W-1:0]     HOLD_V = CNT_W'(HOLD_CYCLES);

   state_t               state;
   logic [SEL_WIDTH-1:0] sel_reg;
   logic [SEL_WIDTH-1:0] pend_reg;
   logic                 force_n;
   logic [CNT_W-1:0]     hold_cnt;
   logic                 sel_valid;
   logic                 sel_bit;
   logic                 gated_n;

   assign sel_valid = (32'(SELECT) < 32'(NUM_RST));

   // Selector may be wider than the input vector; unused codes never match.
   always_comb begin
      sel_bit = 1'b0;
      for (int i = 0; i < NUM_RST; i++) begin
         if (sel_reg == SEL_WIDTH'(i)) sel_bit = RST_IN[i];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         sel_reg  <= INIT_V;
         pend_reg <= INIT_V;
         force_n  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (SELECT_ENABLE && sel_valid && (SELECT != sel_reg)) begin
                  pend_reg <= SELECT;
                  force_n  <= 1'b0;
                  state    <= PRE;
               end else begin
                  force_n  <= 1'b1;
               end
            end
            // Gate is already closed here, so moving the mux cannot glitch.
            PRE: begin
               sel_reg  <= pend_reg;
               hold_cnt <= HOLD_V;
               state    <= HOLD;
            end
            HOLD: begin
               hold_cnt <= hold_cnt - CNT_W'(1);
               if (hold_cnt == CNT_W'(1)) begin
                  force_n <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               force_n <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign gated_n = force_n & sel_bit;
   assign SEL_OUT = sel_reg;
   assign BUSY    = (state != IDLE);

`ifdef RESET_MUX_N_SYNC_EN
   reset_sync_n u_sync (
      .CLK       (CLK),
      .ARST_N    (gated_n),
      .RST_N_OUT (RST_OUT)
   );
`else
   assign RST_OUT = gated_n;
`endif

endmodule

// File: tb/tb_reset_mux_n.sv
// Directed bench for reset_mux_n with a timeline model of the switchover rules.
module tb_reset_mux_n;

   localparam int NUM  = 4;
   localparam int SW   = 3;
   localparam int HOLD = 2;
   localparam int INIT = 0;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [SW-1:0] SELECT = '0;
   logic          SELECT_ENABLE = 1'b0;
   logic [NUM-1:0] RST_IN = 4'hF;
   logic          RST_OUT;
   logic [SW-1:0] SEL_OUT;
   logic          BUSY;

   int n_cmp = 0;
   int n_bad = 0;

   reset_mux_n #(
      .NUM_RST     (NUM),
      .SEL_WIDTH   (SW),
      .HOLD_CYCLES (HOLD),
      .INIT_SEL    (INIT)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .SELECT        (SELECT),
      .SELECT_ENABLE (SELECT_ENABLE),
      .RST_IN        (RST_IN),
      .RST_OUT       (RST_OUT),
      .SEL_OUT       (SEL_OUT),
      .BUSY          (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: edges counted since reset release; an accepted request at edge k
   // keeps the output forced for edges k..k+HOLD and moves the selector at k+1.
   int m_edge = 0;
   int m_acc  = 0;
   bit m_armed = 1'b0;
   bit m_rel   = 1'b0;
   int m_old  = INIT;
   int m_new  = INIT;
   int m_hi   = 0;
   bit m_g;
   int m_s;

   function automatic int m_sel();
      return (m_armed && (m_edge >= m_acc + 1)) ? m_new : m_old;
   endfunction

   function automatic bit m_busy();
      return m_armed && (m_edge <= m_acc + HOLD);
   endfunction

   function automatic bit m_gate();
      return m_rel && !m_busy() && RST_IN[m_sel()];
   endfunction

   function automatic bit m_out();
`ifdef RESET_MUX_N_SYNC_EN
      return m_gate() && (m_hi >= 2);
`else
      return m_gate();
`endif
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_edge  = 0;
         m_armed = 1'b0;
         m_rel   = 1'b0;
         m_old   = INIT;
         m_new   = INIT;
         m_hi    = 0;
      end else begin
         m_g = m_gate();
         m_s = m_sel();
         if (!m_busy() && SELECT_ENABLE && (int'(SELECT) < NUM) && (int'(SELECT) != m_s)) begin
            m_armed = 1'b1;
            m_acc   = m_edge + 1;
            m_old   = m_s;
            m_new   = int'(SELECT);
         end
         m_edge++;
         m_rel = 1'b1;
         m_hi  = m_g ? m_hi + 1 : 0;
         if (!m_gate()) m_hi = 0;
      end
   end

   always @(RST_IN) begin
      if (!m_gate()) m_hi = 0;
   end

   always @(negedge CLK) begin
      chk("cyc_rst_out", RST_OUT, m_out());
      chk("cyc_busy", BUSY, m_busy());
      chk("cyc_sel_out", SEL_OUT, m_sel());
   end

   initial begin
      // Reset and release
      repeat (2) @(negedge CLK);
      chk("reset_rst_out", RST_OUT, 0);
      chk("reset_sel_out", SEL_OUT, 0);
      chk("reset_busy", BUSY, 0);
      #1 RST_N = 1'b1;
      @(negedge CLK);
`ifdef RESET_MUX_N_SYNC_EN
      chk("release_sync_wait", RST_OUT, 0);
      repeat (2) @(negedge CLK);
`endif
      chk("release_rst_out", RST_OUT, 1);

      // Switchover to source 2
      #1 SELECT = 3'd2; SELECT_ENABLE = 1'b1;
      @(negedge CLK);
      chk("sw_k_rst_out", RST_OUT, 0);
      chk("sw_k_busy", BUSY, 1);
      chk("sw_k_sel", SEL_OUT, 0);
      #1 SELECT_ENABLE = 1'b0;
      @(negedge CLK);
      chk("sw_k1_sel", SEL_OUT, 2);
      chk("sw_k1_rst_out", RST_OUT, 0);
      @(negedge CLK);
      chk("sw_k2_rst_out", RST_OUT, 0);
      chk("sw_k2_busy", BUSY, 1);
      @(negedge CLK);
      chk("sw_k3_busy", BUSY, 0);
`ifdef RESET_MUX_N_SYNC_EN
      chk("sw_k3_sync_rst_out", RST_OUT, 0);
      @(negedge CLK);
      chk("sw_k4_sync_rst_out", RST_OUT, 0);
      @(negedge CLK);
`endif
      chk("sw_release_rst_out", RST_OUT, 1);

      // Selected input toggles straight through
      #1 RST_IN = 4'b1011;
      #1 chk("comb_fall", RST_OUT, 0);
      RST_IN = 4'hF;
`ifdef RESET_MUX_N_SYNC_EN
      #1 chk("sync_rise_0", RST_OUT, 0);
      @(posedge CLK);
      #1 chk("sync_rise_1", RST_OUT, 0);
      @(posedge CLK);
`endif
      #1 chk("comb_rise", RST_OUT, 1);
      @(negedge CLK);

      // Same selector, then out-of-range selector: both no-ops
      #1 SELECT = 3'd2; SELECT_ENABLE = 1'b1;
      @(negedge CLK);
      chk("same_busy", BUSY, 0);
      chk("same_sel", SEL_OUT, 2);
      chk("same_rst_out", RST_OUT, 1);
      #1 SELECT = 3'd5;
      @(negedge CLK);
      chk("oor_busy", BUSY, 0);
      chk("oor_sel", SEL_OUT, 2);
      chk("oor_rst_out", RST_OUT, 1);

      // Requests during BUSY are dropped
      #1 SELECT = 3'd1;
      @(negedge CLK);
      chk("drop_k_busy", BUSY, 1);
      #1 SELECT = 3'd3;
      repeat (3) @(negedge CLK);
      #1 SELECT_ENABLE = 1'b0;
      @(negedge CLK);
      chk("drop_final_sel", SEL_OUT, 1);
      chk("drop_final_busy", BUSY, 0);

      // Reset dropped during HOLD
      repeat (3) @(negedge CLK);
      #1 SELECT = 3'd3; SELECT_ENABLE = 1'b1;
      @(negedge CLK);
      #1 SELECT_ENABLE = 1'b0;
      @(negedge CLK);
      chk("hold_sel", SEL_OUT, 3);
      chk("hold_busy", BUSY, 1);
      #1 RST_N = 1'b0;
      #1 chk("abort_rst_out", RST_OUT, 0);
      chk("abort_sel", SEL_OUT, 0);
      chk("abort_busy", BUSY, 0);
      repeat (3) @(negedge CLK);
      chk("abort_still_sel", SEL_OUT, 0);
      #1 RST_N = 1'b1;
      @(negedge CLK);
`ifdef RESET_MUX_N_SYNC_EN
      repeat (2) @(negedge CLK);
`endif
      chk("abort_release", RST_OUT, 1);

      // Normal operation after recovery
      #1 SELECT = 3'd1; SELECT_ENABLE = 1'b1;
      @(negedge CLK);
      #1 SELECT_ENABLE = 1'b0;
      repeat (6) @(negedge CLK);
      chk("recover_sel", SEL_OUT, 1);
      chk("recover_busy", BUSY, 0);
      chk("recover_rst_out", RST_OUT, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
